// File: rtl/decoder_x4_pulse_if.sv
// Code-side and line-side signals of the pulse-stretching 2-to-4 decoder.
// The slave modport is the decoder; the master modport is whoever feeds and observes it.
interface decoder_x4_pulse_if #(
  parameter int unsigned CNT_W = 8
);
  logic [1:0]       z;
  logic             y;
  logic             clr;
  logic [1:0]       cnt_sel;
  logic             ready;
  logic             busy;
  logic [3:0]       x;
  logic [CNT_W-1:0] cnt;

  modport slave (
    input  z,
    input  y,
    input  clr,
    input  cnt_sel,
    output ready,
    output busy,
    output x,
    output cnt
  );

  modport master (
    output z,
    output y,
    output clr,
    output cnt_sel,
    input  ready,
    input  busy,
    input  x,
    input  cnt
  );
endinterface

// File: rtl/decoder_x4_pulse.sv
// Sequential 2-to-4 decoder: each accepted code becomes a one-hot pulse HOLD cycles long,
// followed by a one-cycle gap, with per-line saturating event counters.
module decoder_x4_pulse #(
  parameter int unsigned HOLD  = 4,
  parameter int unsigned CNT_W = 8
) (
  input logic                clk_i,
  input logic                reset_i,
  decoder_x4_pulse_if.slave  dec_io
);

  localparam int unsigned HoldW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HoldW-1:0] HoldLoad = HoldW'(HOLD - 1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StGap
  } state_e;

  state_e           state_q, state_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [3:0]       x_q, x_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic             accept;

  assign accept = (state_q == StIdle) && dec_io.y;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    x_d     = x_q;
    unique case (state_q)
      StIdle: begin
        if (dec_io.y) begin
          x_d     = 4'(4'b0001 << dec_io.z);
          hold_d  = HoldLoad;
          state_d = StDrive;
        end else begin
          x_d = 4'b0000;
        end
      end
      StDrive: begin
        if (hold_q != '0) begin
          hold_d = hold_q - 1'b1;
        end else begin
          x_d     = 4'b0000;
          state_d = StGap;
        end
      end
      StGap: begin
        x_d     = 4'b0000;
        state_d = StIdle;
      end
      default: begin
        x_d     = 4'b0000;
        state_d = StIdle;
      end
    endcase
  end

  // A clear coinciding with an acceptance still records that one event.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = dec_io.clr ? '0 : cnt_q[i];
      if (accept && (dec_io.z == 2'(i))) begin
        if (dec_io.clr) begin
          cnt_d[i] = CNT_W'(1);
        end else if (cnt_q[i] != CntMax) begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      hold_q  <= '0;
      x_q     <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      x_q     <= x_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign dec_io.ready = (state_q == StIdle);
  assign dec_io.busy  = (state_q != StIdle);
  assign dec_io.x     = x_q;
  assign dec_io.cnt   = cnt_q[dec_io.cnt_sel];

endmodule

// File: tb/tb_decoder_x4_pulse.sv
// Directed bench for decoder_x4_pulse: a vector table on a HOLD=4 instance plus hand-written
// sequences for counter saturation (CNT_W=2) and the HOLD=1 corner.
module tb_decoder_x4_pulse;

  logic clk;
  logic rst_a, rst_b, rst_c;
  int   checks;
  int   errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  decoder_x4_pulse_if #(.CNT_W(8)) if_a ();
  decoder_x4_pulse_if #(.CNT_W(2)) if_b ();
  decoder_x4_pulse_if #(.CNT_W(8)) if_c ();

  decoder_x4_pulse #(.HOLD(4), .CNT_W(8)) u_a (.clk_i(clk), .reset_i(rst_a), .dec_io(if_a));
  decoder_x4_pulse #(.HOLD(4), .CNT_W(2)) u_b (.clk_i(clk), .reset_i(rst_b), .dec_io(if_b));
  decoder_x4_pulse #(.HOLD(1), .CNT_W(8)) u_c (.clk_i(clk), .reset_i(rst_c), .dec_io(if_c));

  typedef struct {
    logic       rst;
    logic       y;
    logic [1:0] z;
    logic       clr;
    logic [1:0] sel;
    logic [3:0] ex;
    logic       er;
    logic       eb;
    logic [7:0] ec;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic rst, input logic y, input logic [1:0] z,
                              input logic clr, input logic [1:0] sel, input logic [3:0] ex,
                              input logic er, input logic eb, input logic [7:0] ec);
    vec_t v;
    v.rst = rst; v.y = y; v.z = z; v.clr = clr; v.sel = sel;
    v.ex = ex; v.er = er; v.eb = eb; v.ec = ec;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    if_a.y = 1'b0; if_a.z = 2'd0; if_a.clr = 1'b0; if_a.cnt_sel = 2'd0;
    if_b.y = 1'b0; if_b.z = 2'd0; if_b.clr = 1'b0; if_b.cnt_sel = 2'd0;
    if_c.y = 1'b0; if_c.z = 2'd0; if_c.clr = 1'b0; if_c.cnt_sel = 2'd0;

    // Single code z=2: four cycles of 0100, one gap, then ready.
    add(1, 1, 0, 1, 2, 4'b0000, 1, 0, 0);
    add(0, 1, 2, 0, 2, 4'b0100, 0, 1, 1);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 2, 4'b0100, 0, 1, 1);
    add(0, 0, 0, 0, 2, 4'b0000, 0, 1, 1);
    add(0, 0, 0, 0, 2, 4'b0000, 1, 0, 1);
    add(0, 0, 0, 0, 0, 4'b0000, 1, 0, 0);
    add(0, 0, 0, 0, 1, 4'b0000, 1, 0, 0);
    add(0, 0, 0, 0, 3, 4'b0000, 1, 0, 0);

    // y held with z=3 for 18 edges: accepted at 0, 6, 12.
    add(1, 0, 0, 0, 3, 4'b0000, 1, 0, 0);
    for (int k = 0; k < 18; k++) begin
      add(0, 1, 3, 0, 3, ((k % 6) < 4) ? 4'b1000 : 4'b0000, (k % 6) == 5, (k % 6) != 5,
          8'(k / 6 + 1));
    end

    // Requests during DRIVE are dropped; held request is taken after the gap.
    add(1, 0, 0, 0, 1, 4'b0000, 1, 0, 0);
    add(0, 1, 0, 0, 1, 4'b0001, 0, 1, 0);
    for (int i = 0; i < 3; i++) add(0, 1, 1, 0, 1, 4'b0001, 0, 1, 0);
    add(0, 1, 1, 0, 1, 4'b0000, 0, 1, 0);
    add(0, 1, 1, 0, 1, 4'b0000, 1, 0, 0);
    add(0, 1, 1, 0, 1, 4'b0010, 0, 1, 1);

    // Reset in the second DRIVE cycle aborts the pulse and clears counters.
    add(0, 0, 0, 0, 0, 4'b0010, 0, 1, 1);
    add(1, 1, 2, 0, 1, 4'b0000, 1, 0, 0);
    for (int s = 0; s < 4; s++) add(0, 0, 0, 0, 2'(s), 4'b0000, 1, 0, 0);
    add(0, 0, 0, 0, 0, 4'b0000, 1, 0, 0);

    foreach (tbl[i]) begin
      rst_a = tbl[i].rst;
      if_a.y = tbl[i].y; if_a.z = tbl[i].z; if_a.clr = tbl[i].clr; if_a.cnt_sel = tbl[i].sel;
      tick();
      check($sformatf("vec%0d x", i), 32'(if_a.x), 32'(tbl[i].ex));
      check($sformatf("vec%0d ready", i), 32'(if_a.ready), 32'(tbl[i].er));
      check($sformatf("vec%0d busy", i), 32'(if_a.busy), 32'(tbl[i].eb));
      check($sformatf("vec%0d cnt", i), 32'(if_a.cnt), 32'(tbl[i].ec));
    end
    rst_a = 1'b0;
    if_a.y = 1'b0;

    // CNT_W=2: five z=0 acceptances saturate at 3; clr behaviour.
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    if_b.y = 1'b1; if_b.z = 2'd0; if_b.cnt_sel = 2'd0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if ((k % 6) == 0) begin
        check($sformatf("sat acc%0d cnt0", k / 6), 32'(if_b.cnt),
              ((k / 6 + 1) > 3) ? 32'd3 : 32'(k / 6 + 1));
      end
    end
    check("sat ready", 32'(if_b.ready), 32'd1);
    if_b.clr = 1'b1;
    tick();
    check("clr+acc cnt0", 32'(if_b.cnt), 32'd1);
    if_b.y = 1'b0;
    tick();
    check("clr alone cnt0", 32'(if_b.cnt), 32'd0);
    if_b.clr = 1'b0;

    // HOLD=1: one-hot pulse every 3 cycles, z advanced per acceptance.
    rst_c = 1'b1;
    tick();
    rst_c = 1'b0;
    if_c.y = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if_c.z = 2'((k / 3) % 4);
      tick();
      check($sformatf("h1 edge%0d x", k), 32'(if_c.x),
            ((k % 3) == 0) ? 32'(4'b0001 << ((k / 3) % 4)) : 32'd0);
      check($sformatf("h1 edge%0d ready", k), 32'(if_c.ready), ((k % 3) == 2) ? 32'd1 : 32'd0);
    end
    if_c.y = 1'b0;
    for (int s = 0; s < 4; s++) begin
      if_c.cnt_sel = 2'(s);
      #1;
      check($sformatf("h1 cnt%0d", s), 32'(if_c.cnt), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decoder_x4_pulse.md
# decoder_x4_pulse

Sequential 2-to-4 decoder, the receiving end of the 4-input priority encoder's output code (2-bit index plus valid flag). Each accepted code is turned back into a one-hot line vector held for a programmable number of cycles. The block applies ready-based flow control and keeps per-line saturating event counters for the bench and debug readout.

## Interface
- `HOLD`, default 4: number of cycles the one-hot output stays asserted per accepted code; legal range ≥1.
- `CNT_W`, default 8: width of each per-line event counter.

- `clk`  in  1  single clock, rising-edge.
- `reset`  in  1  synchronous, active-high; has priority over every other input.
- `z`  in  2  encoded line index (`z[1]` MSB); sampled only on an acceptance edge.
- `y`  in  1  code valid.
- `clr`  in  1  synchronous clear of all event counters.
- `cnt_sel`  in  2  selects which counter drives `cnt`.
- `ready`  out  1  block can accept a code this cycle.
- `busy`  out  1  pulse or gap in progress.
- `x`  out  4  one-hot decoded output, registered.
- `cnt`  out  CNT_W  value of counter `cnt_sel`, via combinational mux.

## Operation
- FSM states: IDLE, DRIVE, GAP. The state is registered.
  - `ready` = (state == IDLE).
  - `busy` = (state != IDLE).
- Acceptance edge: a rising edge with `reset`=0, state IDLE and `y`=1.
- IDLE:
  - On an acceptance edge: `x` <= onehot(`z`) (`z`=0 -> 0001, 1 -> 0010, 2 -> 0100, 3 -> 1000).
  - Load the hold counter with HOLD-1 and go to DRIVE.
  - With `y`=0, stay in IDLE, `x`=0, and ignore `z`.
- DRIVE:
  - `x` holds its value. `y` and `z` are ignored: no queueing and no counter update.
  - If the hold counter is >0, decrement it.
  - If it is 0: `x` <= 0 and go to GAP.
- GAP: `x`=0 for exactly one cycle, then go to IDLE.
- Event counters `c0`..`c3`, each CNT_W bits:
  - On an acceptance edge, `c[z]` increments by 1.
  - They saturate at 2^CNT_W-1 and never wrap.
- `clr`=1 clears all counters on that edge.
  - If `clr` coincides with an acceptance edge, the accepted line's counter becomes 1 and all others become 0.
- `cnt` = `c[cnt_sel]`, combinational from the registered counters.
- Reset edge:
  - State goes to IDLE, `x`=0 and all counters are 0.
  - `y` and `clr` are ignored on that edge.
  - Reset mid-DRIVE aborts the pulse; `x` is 0 in the following cycle.
- After reset, `ready`=1 and `busy`=0 on the first cycle with `reset` deasserted.

## Timing
- Acceptance at edge E0:
  - `x` is one-hot in cycles E0+1 .. E0+HOLD, exactly HOLD cycles.
  - `x`=0 and `busy`=1 in cycle E0+HOLD+1 (GAP).
  - `ready`=1 from cycle E0+HOLD+2.
- The earliest next acceptance is edge E0+HOLD+2, so maximum throughput is one code per HOLD+2 cycles. With `y` held high, acceptances occur exactly every HOLD+2 cycles.
- Latency from the acceptance edge to `x` valid is 1 cycle. The counter update is visible on `cnt` 1 cycle after the acceptance edge.
- HOLD=1: DRIVE lasts one cycle (the counter loads 0 and exits immediately).
- `x` is never non-zero outside DRIVE, and never has more than one bit set.

## Test plan
- Reset, then `y`=1 with `z`=2 for one cycle, HOLD=4:
  - `x`=0100 for 4 cycles, then 0 for 1 cycle.
  - `ready`=1 two cycles after `x` drops.
  - With `cnt_sel`=2, `cnt`=1; other counters read 0.
- `y` held 1 with `z`=3 for 18 cycles after reset, HOLD=4:
  - Acceptances at cycles 0, 6 and 12.
  - `cnt_sel`=3 gives `cnt`=3.
- During DRIVE of code 0, drive `y`=1 with `z`=1:
  - `x` stays 0001 for the full pulse.
  - `c1` stays 0.
  - After GAP, a held request is accepted and `x`=0010.
- Assert `reset` in the 2nd DRIVE cycle with nonzero counters:
  - Next cycle has `x`=0, `ready`=1, `busy`=0 and all counters 0.
  - No residual pulse follows.
- CNT_W=2, five acceptances of `z`=0:
  - `cnt0`=3 (saturated).
  - `clr` on the same edge as a `z`=0 acceptance leaves `cnt0`=1.
  - `clr` alone leaves `cnt0`=0.
- HOLD=1 with `y` held 1, `z` cycling 0,1,2,3:
  - `x` is 0001, 0000, 0000, 0010, ... with a one-hot pulse every 3 cycles.
  - Each counter equals 1 after four acceptances.
